// File: rtl/lcd_text_buffer_if.sv
// Operation handshake between a text source and the LCD text buffer.
interface lcd_text_buffer_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [7:0] in_data;

    modport master (output in_valid, output in_op, output in_data, input in_ready);
    modport slave  (input in_valid, input in_op, input in_data, output in_ready);
endinterface

// File: rtl/lcd_text_buffer.sv
// ROWS x COLS character store with write cursor, wrap/scroll at end of screen,
// and an independent registered read port for the LCD controller.
module lcd_text_buffer #(
    parameter int          ROWS  = 2,
    parameter int          COLS  = 16,
    parameter logic [7:0]  FILL  = 8'h20,
    localparam int         DEPTH = ROWS * COLS,
    localparam int         IDX_W = $clog2(DEPTH),
    localparam int         RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int         CW    = $clog2(COLS)
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    lcd_text_buffer_if.slave  bus,
    input  logic              mode_scroll,
    input  logic [IDX_W-1:0]  rd_index,
    output logic [7:0]        rd_char,
    output logic [RW-1:0]     cursor_row,
    output logic [CW-1:0]     cursor_col,
    output logic              busy
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_CLEAR       = 3'd1;
    localparam logic [2:0] S_SCROLL_RD   = 3'd2;
    localparam logic [2:0] S_SCROLL_WR   = 3'd3;
    localparam logic [2:0] S_SCROLL_FILL = 3'd4;

    localparam logic [1:0] OP_PUT     = 2'd0;
    localparam logic [1:0] OP_NEWLINE = 2'd1;
    localparam logic [1:0] OP_CLEAR   = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] COPY_LAST = IDX_W'((ROWS > 1) ? (ROWS - 1) * COLS - 1 : 0);
    localparam logic [IDX_W-1:0] FILL_BASE = IDX_W'((ROWS - 1) * COLS);
    localparam logic [RW-1:0]    LAST_ROW  = RW'(ROWS - 1);
    localparam logic [CW-1:0]    LAST_COL  = CW'(COLS - 1);
    localparam logic [2:0]       S_SCROLL_START = (ROWS > 1) ? S_SCROLL_RD : S_SCROLL_FILL;

    logic [2:0]       state;
    logic [IDX_W-1:0] seq;
    logic [7:0]       scr_data;
    logic [7:0]       mem [DEPTH];

    logic             idle;
    logic             fire;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] src_idx;
    logic             we;
    logic [IDX_W-1:0] waddr;
    logic [7:0]       wdata;

    assign idle         = (state == S_IDLE);
    assign bus.in_ready = idle;
    assign busy         = !idle;
    assign fire         = bus.in_valid && idle;
    assign cur_idx      = IDX_W'(int'(cursor_row) * COLS + int'(cursor_col));
    assign src_idx      = IDX_W'(int'(seq) + COLS);

    // Single write port shared by PUT, clear and both scroll phases.
    always_comb begin
        we    = 1'b0;
        waddr = seq;
        wdata = FILL;
        case (state)
            S_IDLE: begin
                if (fire && bus.in_op == OP_PUT) begin
                    we    = 1'b1;
                    waddr = cur_idx;
                    wdata = bus.in_data;
                end
            end
            S_CLEAR, S_SCROLL_FILL: we = 1'b1;
            S_SCROLL_WR: begin
                we    = 1'b1;
                wdata = scr_data;
            end
            default: ;
        endcase
        // A reset edge must not commit an in-flight copy or fill write.
        if (!rst_n) we = 1'b0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (we) mem[waddr] <= wdata;
        if (state == S_SCROLL_RD) scr_data <= mem[src_idx];
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) rd_char <= '0;
        else        rd_char <= mem[rd_index];
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state      <= S_CLEAR;
            seq        <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fire) begin
                        if (bus.in_op == OP_CLEAR) begin
                            cursor_row <= '0;
                            cursor_col <= '0;
                            seq        <= '0;
                            state      <= S_CLEAR;
                        end else if (bus.in_op == OP_PUT && cursor_col != LAST_COL) begin
                            cursor_col <= cursor_col + CW'(1);
                        end else if (bus.in_op == OP_PUT || bus.in_op == OP_NEWLINE) begin
                            cursor_col <= '0;
                            if (cursor_row != LAST_ROW) begin
                                cursor_row <= cursor_row + RW'(1);
                            end else if (mode_scroll) begin
                                cursor_row <= LAST_ROW;
                                seq        <= '0;
                                state      <= S_SCROLL_START;
                            end else begin
                                cursor_row <= '0;
                            end
                        end else begin
                            cursor_row <= '0;
                            cursor_col <= '0;
                        end
                    end
                end
                S_CLEAR, S_SCROLL_FILL: begin
                    if (seq == LAST_IDX) state <= S_IDLE;
                    else                 seq   <= seq + IDX_W'(1);
                end
                S_SCROLL_RD: state <= S_SCROLL_WR;
                S_SCROLL_WR: begin
                    if (seq == COPY_LAST) begin
                        seq   <= FILL_BASE;
                        state <= S_SCROLL_FILL;
                    end else begin
                        seq   <= seq + IDX_W'(1);
                        state <= S_SCROLL_RD;
                    end
                end
                default: begin
                    seq   <= '0;
                    state <= S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed bench for lcd_text_buffer; display reads are checked by a scoreboard monitor.
module tb_lcd_text_buffer;
    localparam int DEPTH = 32;
    localparam logic [1:0] OP_PUT = 2'd0, OP_NL = 2'd1, OP_CLR = 2'd2, OP_HOME = 2'd3;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n;
    logic       mode_scroll;
    logic [4:0] rd_index;
    logic [7:0] rd_char;
    logic [0:0] cursor_row;
    logic [3:0] cursor_col;
    logic       busy;

    lcd_text_buffer_if bus();

    lcd_text_buffer #(.ROWS(2), .COLS(16), .FILL(8'h20)) dut (
        .CLOCK_50    (CLOCK_50),
        .rst_n       (rst_n),
        .bus         (bus),
        .mode_scroll (mode_scroll),
        .rd_index    (rd_index),
        .rd_char     (rd_char),
        .cursor_row  (cursor_row),
        .cursor_col  (cursor_col),
        .busy        (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int         idx;
        logic [7:0] want;
    } rd_exp_t;

    rd_exp_t sb[$];
    rd_exp_t mon_e;
    logic    rd_req  = 1'b0;
    logic    rd_pend = 1'b0;
    int      n_pass  = 0;
    int      n_checks = 0;

    always @(posedge CLOCK_50) rd_pend <= rd_req;

    // Read data is valid one cycle after the address; compare on the falling edge.
    always @(negedge CLOCK_50) begin
        if (rd_pend) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL rd_unexpected: got %02h with no expected entry", rd_char);
            end else begin
                mon_e = sb.pop_front();
                if (rd_char === mon_e.want) n_pass++;
                else $display("FAIL rd[%0d]: got %02h expected %02h", mon_e.idx, rd_char, mon_e.want);
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    task automatic rd(input int idx, input logic [7:0] want);
        rd_index = 5'(idx);
        rd_req   = 1'b1;
        sb.push_back('{idx: idx, want: want});
        tick();
        rd_req = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [7:0] d, output int waited);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        waited       = 0;
        while (!bus.in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) chk("op_accept_timeout", 0, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int w, n, wsum, acc, acc_cyc;
        logic busy_seen;
        logic [7:0] hello [5];
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

        rst_n = 1'b0; mode_scroll = 1'b0; rd_index = '0;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_data = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        wait_idle(n);

        // Reset and clear
        rst_n = 1'b0;
        tick();
        chk("rst_busy", busy, 1);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_rd_char", rd_char, 0);
        rst_n = 1'b1;
        wait_idle(n);
        chk("rst_clear_cycles", n, 32);
        chk("rst_ready_after", bus.in_ready, 1);
        chk("rst_cursor_row", cursor_row, 0);
        chk("rst_cursor_col", cursor_col, 0);
        for (int i = 0; i < DEPTH; i++) rd(i, 8'h20);

        // HELLO back-to-back
        wsum = 0;
        for (int i = 0; i < 5; i++) begin
            do_op(OP_PUT, hello[i], w);
            wsum += w;
        end
        chk("hello_stalls", wsum, 0);
        chk("hello_cursor_row", cursor_row, 0);
        chk("hello_cursor_col", cursor_col, 5);
        for (int i = 0; i < 5; i++) rd(i, hello[i]);
        rd(5, 8'h20);

        // Wrap at end of screen
        do_op(OP_HOME, 8'h00, w);
        busy_seen = 1'b0;
        for (int i = 0; i < 33; i++) begin
            do_op(OP_PUT, 8'(8'h41 + i), w);
            if (busy || w != 0) busy_seen = 1'b1;
        end
        chk("wrap_busy_seen", busy_seen, 0);
        chk("wrap_cursor_row", cursor_row, 0);
        chk("wrap_cursor_col", cursor_col, 1);
        rd(0, 8'h61);
        rd(1, 8'h42);
        rd(16, 8'h51);
        rd(31, 8'h60);

        // Scroll at end of screen
        do_op(OP_CLR, 8'h00, w);
        wait_idle(n);
        chk("op_clear_cycles", n, 32);
        mode_scroll = 1'b1;
        for (int i = 0; i < 16; i++) do_op(OP_PUT, 8'h41, w);
        for (int i = 0; i < 16; i++) do_op(OP_PUT, 8'h42, w);
        wait_idle(n);
        chk("scroll_busy_cycles", n, 48);
        chk("scroll_cursor_row", cursor_row, 1);
        chk("scroll_cursor_col", cursor_col, 0);
        for (int i = 0; i < 16; i++) rd(i, 8'h42);
        for (int i = 16; i < DEPTH; i++) rd(i, 8'h20);
        do_op(OP_NL, 8'h00, w);
        wait_idle(n);
        chk("nl_scroll_cycles", n, 48);
        chk("nl_cursor_row", cursor_row, 1);
        chk("nl_cursor_col", cursor_col, 0);
        for (int i = 0; i < DEPTH; i++) rd(i, 8'h20);

        // Backpressure during clear
        do_op(OP_CLR, 8'h00, w);
        bus.in_valid = 1'b1; bus.in_op = OP_PUT; bus.in_data = 8'h5A;
        acc = 0; acc_cyc = -1;
        for (int c = 0; c < 60; c++) begin
            if (bus.in_valid && bus.in_ready) begin
                acc++;
                acc_cyc = c;
                tick();
                bus.in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        bus.in_valid = 1'b0;
        chk("bp_accept_count", acc, 1);
        chk("bp_accept_cycle", acc_cyc, 32);
        chk("bp_cursor_row", cursor_row, 0);
        chk("bp_cursor_col", cursor_col, 1);
        rd(0, 8'h5A);
        rd(1, 8'h20);

        // Reset in the middle of a scroll
        mode_scroll = 1'b0;
        do_op(OP_HOME, 8'h00, w);
        for (int i = 0; i < 31; i++) do_op(OP_PUT, 8'(8'h61 + i), w);
        chk("pre_cursor_col", cursor_col, 15);
        rd(20, 8'h75);
        mode_scroll = 1'b1;
        do_op(OP_NL, 8'h00, w);
        repeat (10) tick();
        chk("midscroll_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        chk("midrst_rd_char", rd_char, 0);
        chk("midrst_busy", busy, 1);
        chk("midrst_cursor_row", cursor_row, 0);
        chk("midrst_cursor_col", cursor_col, 0);
        rst_n = 1'b1;
        wait_idle(n);
        chk("midrst_clear_cycles", n, 32);
        repeat (50) tick();
        chk("midrst_idle_busy", busy, 0);
        for (int i = 0; i < DEPTH; i++) rd(i, 8'h20);
        chk("midrst_cursor_row2", cursor_row, 0);
        chk("midrst_cursor_col2", cursor_col, 0);

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
